// File: rtl/mult_arbiter.sv
// Two-requester front end for a shared sequential 4x4 multiplier (IDLE/GRANT/WAIT/DONE).
// Define MULT_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module mult_arbiter #(
  parameter int LATENCY = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  output logic       gnt0,
  output logic       done0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt1,
  output logic       done1,
  output logic [7:0] result,
  output logic       busy,
  output logic       mul_rst,
  output logic       mul_start,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic [7:0] mul_product
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       sel;
  logic       pick;

`ifdef MULT_ARB_RR_EN
  logic last;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    pick = ~req0;
    if (req0 && req1) pick = ~last;
  end

  always_ff @(posedge clk) begin
    if (!rst)                last <= 1'b1;
    else if (state == GRANT) last <= sel;
  end
`else
  always_comb begin
    pick = ~req0;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = GRANT;
      GRANT:   state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      sel    <= 1'b0;
      result <= 8'd0;
      mul_a  <= 4'd0;
      mul_b  <= 4'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel   <= pick;
            mul_a <= pick ? a1 : a0;
            mul_b <= pick ? b1 : b0;
          end
        end
        GRANT: cnt <= 4'(LATENCY - 1);
        WAIT: begin
          // Counter runs LATENCY-1 down to 0, so WAIT spans exactly LATENCY cycles.
          if (cnt == 4'd0) result <= mul_product;
          else             cnt    <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign gnt0      = (state == GRANT) && !sel;
  assign gnt1      = (state == GRANT) &&  sel;
  assign done0     = (state == DONE)  && !sel;
  assign done1     = (state == DONE)  &&  sel;
  assign mul_start = (state == GRANT);
  assign busy      = (state != IDLE);
  assign mul_rst   = ~rst;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: LATENCY=10 instance plus a LATENCY=1 instance,
// each paired with a behavioural sequential multiplier.
module tb_mult_arbiter;

  localparam int LA = 10;
  localparam int LB = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       req0, req1, gnt0, gnt1, done0, done1, busy, mul_rst, mul_start;
  logic [3:0] a0, b0, a1, b1, mul_a, mul_b;
  logic [7:0] result, mul_product;

  logic       r0_l, r1_l, g0_l, g1_l, d0_l, d1_l, busy_l, mrst_l, mstart_l;
  logic [3:0] a0_l, b0_l, a1_l, b1_l, ma_l, mb_l;
  logic [7:0] res_l, mprod_l;

  int n_tests = 0;
  int n_fail  = 0;

  mult_arbiter #(.LATENCY(LA)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1),
    .result(result), .busy(busy), .mul_rst(mul_rst), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product)
  );

  mult_arbiter #(.LATENCY(LB)) dut_l1 (
    .clk(clk), .rst(rst),
    .req0(r0_l), .a0(a0_l), .b0(b0_l), .gnt0(g0_l), .done0(d0_l),
    .req1(r1_l), .a1(a1_l), .b1(b1_l), .gnt1(g1_l), .done1(d1_l),
    .result(res_l), .busy(busy_l), .mul_rst(mrst_l), .mul_start(mstart_l),
    .mul_a(ma_l), .mul_b(mb_l), .mul_product(mprod_l)
  );

  // Multiplier models: product shows 0 until LATENCY cycles after the start edge.
  logic [3:0] mc_a, mc_l;
  logic [7:0] ms_a, ms_l;

  always @(posedge clk) begin
    if (mul_rst) begin
      mc_a <= 4'd0; mul_product <= 8'd0; ms_a <= 8'd0;
    end else if (mul_start) begin
      ms_a <= {4'b0, mul_a} * {4'b0, mul_b};
      mc_a <= 4'(LA - 1);
      mul_product <= (LA == 1) ? {4'b0, mul_a} * {4'b0, mul_b} : 8'd0;
    end else if (mc_a != 4'd0) begin
      mc_a <= mc_a - 4'd1;
      if (mc_a == 4'd1) mul_product <= ms_a;
    end
  end

  always @(posedge clk) begin
    if (mrst_l) begin
      mc_l <= 4'd0; mprod_l <= 8'd0; ms_l <= 8'd0;
    end else if (mstart_l) begin
      ms_l <= {4'b0, ma_l} * {4'b0, mb_l};
      mc_l <= 4'(LB - 1);
      mprod_l <= (LB == 1) ? {4'b0, ma_l} * {4'b0, mb_l} : 8'd0;
    end else if (mc_l != 4'd0) begin
      mc_l <= mc_l - 4'd1;
      if (mc_l == 4'd1) mprod_l <= ms_l;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps until the selected done pulse (bounded); reports cycle count and any grant seen.
  task automatic wait_done(input bit which, output int n, output bit gseen);
    n = 0;
    gseen = 1'b0;
    do begin
      step();
      n++;
      if (gnt0 || gnt1) gseen = 1'b1;
    end while (!(which ? done1 : done0) && n < 40);
  endtask

  int n;
  bit gs;
  bit seen;

  initial begin
    rst = 1'b0;
    req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    r0_l = 0; r1_l = 0; a0_l = 0; b0_l = 0; a1_l = 0; b1_l = 0;

    // Reset
    step(); step();
    chk("rst_busy",    32'(busy), 0);
    chk("rst_gnt",     32'({gnt0, gnt1, mul_start}), 0);
    chk("rst_done",    32'({done0, done1}), 0);
    chk("rst_result",  32'(result), 0);
    chk("rst_mul_ab",  32'({mul_a, mul_b}), 0);
    chk("rst_mul_rst", 32'(mul_rst), 1);
    rst = 1'b1;
    step();
    chk("run_mul_rst", 32'(mul_rst), 0);
    chk("idle_busy",   32'(busy), 0);

    // Requester 0: 6*3
    req0 = 1; a0 = 4'd6; b0 = 4'd3;
    step();
    chk("t1_gnt0",  32'(gnt0), 1);
    chk("t1_gnt1",  32'(gnt1), 0);
    chk("t1_start", 32'(mul_start), 1);
    chk("t1_mul_ab", 32'({mul_a, mul_b}), 32'({4'd6, 4'd3}));
    chk("t1_busy",  32'(busy), 1);
    req0 = 0;
    wait_done(1'b0, n, gs);
    chk("t1_done_lat", 32'(n), 11);
    chk("t1_result",   32'(result), 18);
    chk("t1_done1",    32'(done1), 0);
    step();
    chk("t1_done_pulse", 32'(done0), 0);
    chk("t1_idle_busy",  32'(busy), 0);
    chk("t1_hold",       32'(result), 18);

    // Requester 1: 15*15
    req1 = 1; a1 = 4'd15; b1 = 4'd15;
    step();
    chk("t2_gnt1", 32'(gnt1), 1);
    chk("t2_gnt0", 32'(gnt0), 0);
    req1 = 0;
    wait_done(1'b1, n, gs);
    chk("t2_done_lat", 32'(n), 11);
    chk("t2_result",   32'(result), 225);
    chk("t2_done0",    32'(done0), 0);
    step();

    // Requester 1 arrives during requester 0's WAIT: ignored until IDLE
    req0 = 1; a0 = 4'd2; b0 = 4'd7;
    step();
    chk("t4_gnt0", 32'(gnt0), 1);
    req0 = 0;
    step(); step(); step();
    req1 = 1; a1 = 4'd3; b1 = 4'd5;
    wait_done(1'b0, n, gs);
    chk("t4_no_gnt_in_wait", 32'(gs), 0);
    chk("t4_result",   32'(result), 14);
    chk("t4_mul_ab",   32'({mul_a, mul_b}), 32'({4'd2, 4'd7}));
    step();
    chk("t4_idle_gnt1", 32'(gnt1), 0);
    chk("t4_idle_busy", 32'(busy), 0);
    step();
    chk("t4_gnt1_after_idle", 32'(gnt1), 1);
    chk("t4_mul_ab1",   32'({mul_a, mul_b}), 32'({4'd3, 4'd5}));
    req1 = 0;
    wait_done(1'b1, n, gs);
    chk("t4_result1", 32'(result), 15);
    step();

    // Both requesters held together
    req0 = 1; a0 = 4'd2; b0 = 4'd5; req1 = 1; a1 = 4'd4; b1 = 4'd3;
    step();
    chk("t3_first_gnt0", 32'({gnt0, gnt1}), 32'(2'b10));
    wait_done(1'b0, n, gs);
    chk("t3_result_a", 32'(result), 10);
    step(); step();
`ifdef MULT_ARB_RR_EN
    chk("t3_second_gnt1", 32'({gnt0, gnt1}), 32'(2'b01));
    wait_done(1'b1, n, gs);
    chk("t3_result_b", 32'(result), 12);
`else
    chk("t3_second_gnt0", 32'({gnt0, gnt1}), 32'(2'b10));
    wait_done(1'b0, n, gs);
    chk("t3_result_b", 32'(result), 10);
`endif
    step(); step();
    chk("t3_third_gnt0", 32'({gnt0, gnt1}), 32'(2'b10));
    req0 = 0; req1 = 0;
    wait_done(1'b0, n, gs);
    chk("t3_result_c", 32'(result), 10);
    step();

    // Reset during WAIT aborts the transaction
    req0 = 1; a0 = 4'd5; b0 = 4'd5;
    step();
    chk("t5_gnt0", 32'(gnt0), 1);
    req0 = 0;
    step(); step(); step();
    rst = 1'b0;
    #1;
    chk("t5_mul_rst", 32'(mul_rst), 1);
    step();
    chk("t5_busy",   32'(busy), 0);
    chk("t5_outs",   32'({gnt0, gnt1, done0, done1, mul_start}), 0);
    chk("t5_result", 32'(result), 0);
    chk("t5_mul_ab", 32'({mul_a, mul_b}), 0);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done0 || done1 || busy) seen = 1'b1;
    end
    chk("t5_no_done", 32'(seen), 0);
    chk("t5_mul_rst_off", 32'(mul_rst), 0);

    // LATENCY = 1 instance: 9*7
    r0_l = 1; a0_l = 4'd9; b0_l = 4'd7;
    step();
    chk("l1_gnt0", 32'(g0_l), 1);
    r0_l = 0;
    step();
    chk("l1_wait_nodone", 32'(d0_l), 0);
    step();
    chk("l1_done0",  32'(d0_l), 1);
    chk("l1_result", 32'(res_l), 63);
    step();
    chk("l1_idle", 32'({d0_l, busy_l}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
